// File: rtl/modmul_pkg.sv
// Shared types and sizing helpers for the modular arithmetic engine.
package modmul_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // Default engine geometry and the matching step-counter width.
  localparam int unsigned W_DEF   = 256;
  localparam int unsigned DPC_DEF = 1;
  localparam int unsigned CNT_W   = $clog2(W_DEF / DPC_DEF);

  // Counter width for an arbitrary step count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/modmul_step.sv
// One LSB-first double-and-add step of the interleaved modular multiplier.
//   s' = bit ? (s+u >= m ? s+u-m : s+u) : s
//   u' = (2u >= m) ? 2u-m : 2u
module modmul_step #(
  parameter int unsigned WS = 258
) (
  input  logic [WS-1:0] s_i,
  input  logic [WS-1:0] u_i,
  input  logic [WS-1:0] m_i,
  input  logic          bit_i,
  output logic [WS-1:0] s_o,
  output logic [WS-1:0] u_o
);

  logic [WS-1:0] sum;
  logic [WS-1:0] dbl;

  // Conditional accumulate and modular doubling of the running multiplicand.
  always_comb begin
    sum = s_i + u_i;
    dbl = u_i + u_i;
    s_o = s_i;
    if (bit_i) begin
      s_o = (sum >= m_i) ? (sum - m_i) : sum;
    end
    u_o = (dbl >= m_i) ? (dbl - m_i) : dbl;
  end

endmodule

// File: rtl/modmul_engine.sv
// Modular arithmetic engine: a*b mod m, (a+b) mod m, (a-b) mod m with
// valid/ready on operand and result sides.
// Optional build macro MODMUL_RANGE_CHECK_EN: rejects m==0, a>=m or b>=m at
// accept with out_err=1 and p=0.
module modmul_engine
  import modmul_pkg::*;
#(
  parameter int unsigned W   = 256,
  parameter int unsigned DPC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] p,
  output logic         out_err,
  output logic         busy
);

  localparam int unsigned NSTEP = W / DPC;
  localparam int unsigned CW    = cnt_width(NSTEP);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [W+1:0]  u_q, u_d;
  logic [W+1:0]  s_q, s_d;
  logic [W-1:0]  bsh_q, bsh_d;
  logic [W-1:0]  m_q, m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  p_q, p_d;
  logic          err_q, err_d;

  logic          range_fault;
  logic [W+1:0]  m_ext;
  logic [W+1:0]  s_ch [DPC+1];
  logic [W+1:0]  u_ch [DPC+1];
  logic [W:0]    add_t, sub_t;
  logic [W-1:0]  add_res, sub_res;
  logic          last_step;

`ifdef MODMUL_RANGE_CHECK_EN
  assign range_fault = (m == '0) || (a >= m) || (b >= m);
`else
  assign range_fault = 1'b0;
`endif

  assign m_ext     = {2'b00, m_q};
  assign last_step = (cnt_q == CW'(NSTEP - 1));

  // DPC multiplier bits are retired per cycle by chaining identical steps.
  assign s_ch[0] = s_q;
  assign u_ch[0] = u_q;
  for (genvar k = 0; k < DPC; k++) begin : g_step
    modmul_step #(.WS(W + 2)) u_step (
      .s_i  (s_ch[k]),
      .u_i  (u_ch[k]),
      .m_i  (m_ext),
      .bit_i(bsh_q[k]),
      .s_o  (s_ch[k+1]),
      .u_o  (u_ch[k+1])
    );
  end

  // Single-cycle ADD/SUB; a is parked in u_q and b in bsh_q during RUN.
  always_comb begin
    add_t   = {1'b0, u_q[W-1:0]} + {1'b0, bsh_q};
    add_res = (add_t >= {1'b0, m_q}) ? W'(add_t - {1'b0, m_q}) : add_t[W-1:0];
    sub_t   = {1'b0, u_q[W-1:0]} - {1'b0, bsh_q};
    sub_res = sub_t[W] ? W'(sub_t[W-1:0] + m_q) : sub_t[W-1:0];
  end

  // Next-state and datapath update; abort wins over the result handshake.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    u_d     = u_q;
    s_d     = s_q;
    bsh_d   = bsh_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d  = op_e'(op);
          u_d   = {2'b00, a};
          s_d   = '0;
          bsh_d = b;
          m_d   = m;
          cnt_d = '0;
          p_d   = '0;
          err_d = 1'b0;
          if ((op_e'(op) == OP_ILL) || range_fault) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          unique case (op_q)
            OP_MUL: begin
              s_d   = s_ch[DPC];
              u_d   = u_ch[DPC];
              bsh_d = bsh_q >> DPC;
              cnt_d = cnt_q + CW'(1);
              if (last_step) begin
                p_d     = s_ch[DPC][W-1:0];
                state_d = S_DONE;
              end
            end
            OP_ADD: begin
              p_d     = add_res;
              state_d = S_DONE;
            end
            OP_SUB: begin
              p_d     = sub_res;
              state_d = S_DONE;
            end
            default: begin
              p_d     = '0;
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_DONE: begin
        if (abort || out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_MUL;
      u_q   <= '0;
      s_q   <= '0;
      bsh_q <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      p_q   <= '0;
      err_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      u_q   <= u_d;
      s_q   <= s_d;
      bsh_q <= bsh_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      p_q   <= p_d;
      err_q <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign p         = p_q;
  assign out_err   = err_q & out_valid;

endmodule

// File: tb/tb_modmul_engine.sv
// Scoreboard bench for modmul_engine: an 8-bit DPC=1 instance under directed
// and random traffic, plus a 256-bit DPC=4 instance on the secp256k1 prime.
module tb_modmul_engine;
  import modmul_pkg::*;

  localparam int W    = 8;
  localparam int DPC  = 1;
  localparam int NST  = W / DPC;
  localparam int WB   = 256;
  localparam int DPCB = 4;
  localparam logic [WB-1:0] PK1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, abort, out_valid, out_ready, out_err, busy;
  logic [1:0]   op;
  logic [W-1:0] a, b, m, p;

  logic in_valid_b, in_ready_b, out_valid_b, out_err_b, busy_b;
  logic [WB-1:0] a_b, b_b, p_b;

  always #5 clk = ~clk;

  modmul_engine #(.W(W), .DPC(DPC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .m(m), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .out_err(out_err), .busy(busy)
  );

  modmul_engine #(.W(WB), .DPC(DPCB)) dut_big (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .op(2'b00), .a(a_b), .b(b_b), .m(PK1), .abort(1'b0), .out_valid(out_valid_b),
    .out_ready(1'b1), .p(p_b), .out_err(out_err_b), .busy(busy_b)
  );

  typedef struct {
    logic [W-1:0] p;
    logic         err;
    bit           chk_p;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_v = 1'b0;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (bound expired)", name);
  endtask

  function automatic exp_t mk(input int pv, input logic e, input bit cp, input int lat);
    exp_t r;
    r.p = W'(pv); r.err = e; r.chk_p = cp; r.lat = lat;
    return r;
  endfunction

  // Reference: plain integer modular arithmetic.
  function automatic exp_t model(input logic [1:0] o, input int unsigned x, y, md);
    case (o)
      2'b00:   return mk(int'((x * y) % md), 1'b0, 1'b1, NST);
      2'b01:   return mk(int'((x + y) % md), 1'b0, 1'b1, 1);
      2'b10:   return mk(int'((x + md - y) % md), 1'b0, 1'b1, 1);
      default: return mk(0, 1'b1, 1'b1, -1);
    endcase
  endfunction

  // Cycle counter and accept-edge capture.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) acc_cyc = cyc;
  end

  // Random consumer back-pressure during the random phase.
  always @(negedge clk) begin
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop and compare on every rising out_valid.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_v) begin
      if (sb.size() == 0) begin
        fail_now("out_valid_without_request");
      end else begin
        e = sb.pop_front();
        if (e.chk_p) chk("p", p, e.p);
        chk("out_err", out_err, e.err);
        if (e.lat >= 0) chk("latency", cyc - acc_cyc, e.lat);
      end
    end
    prev_v = out_valid;
  end

  // Call at a negedge; holds in_valid for exactly one accept edge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] ia, ib, im,
                       input bit push, input exp_t e);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) fail_now("issue_wait_in_ready");
    if (push) sb.push_back(e);
    op = o; a = ia; b = ib; m = im; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) fail_now("drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [W-1:0]  rec;
    logic [511:0]  prod;
    int            n;
    int unsigned   rm, ra, rb;
    logic [1:0]    ro;

    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; m = '0;
    abort = 1'b0; out_ready = 1'b1; in_valid_b = 1'b0; a_b = '0; b_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_p", p, 0);
    chk("rst_big_in_ready", in_ready_b, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic.
    issue(2'b00, 8'd200, 8'd150, 8'd251, 1, mk(131, 0, 1, 8)); drain();
    issue(2'b01, 8'd200, 8'd100, 8'd251, 1, mk(49, 0, 1, 1));  drain();
    issue(2'b10, 8'd10,  8'd20,  8'd251, 1, mk(241, 0, 1, 1)); drain();
    issue(2'b10, 8'd77,  8'd77,  8'd251, 1, mk(0, 0, 1, 1));   drain();
    issue(2'b11, 8'd5,   8'd6,   8'd251, 1, mk(0, 1, 1, -1));  drain();
`ifdef MODMUL_RANGE_CHECK_EN
    issue(2'b00, 8'd251, 8'd1, 8'd251, 1, mk(0, 1, 1, -1));    drain();
`else
    issue(2'b00, 8'd251, 8'd1, 8'd251, 1, mk(0, 0, 0, 8));     drain();
`endif

    // Consumer stall in DONE, then back-to-back request with no turnaround.
    out_ready = 1'b0;
    issue(2'b00, 8'd200, 8'd150, 8'd251, 1, mk(131, 0, 1, 8));
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) fail_now("stall_wait_valid");
    rec = p;
    chk("stall_p_value", rec, 131);
    repeat (5) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_p_stable", p, rec);
      chk("stall_in_ready", in_ready, 0);
    end
    sb.push_back(mk(49, 0, 1, 1));
    op = 2'b01; a = 8'd200; b = 8'd100; m = 8'd251; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("turnaround_in_ready", in_ready, 1);
    chk("turnaround_out_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("turnaround_accepted_busy", busy, 1);
    drain();

    // Reset mid-MUL discards the operation.
    issue(2'b00, 8'd200, 8'd150, 8'd251, 0, mk(0, 0, 0, -1));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 8'd3, 8'd5, 8'd251, 1, mk(15, 0, 1, 8)); drain();

    // Abort mid-MUL; abort while IDLE is ignored.
    issue(2'b00, 8'd200, 8'd150, 8'd251, 0, mk(0, 0, 0, -1));
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    issue(2'b00, 8'd3, 8'd5, 8'd251, 1, mk(15, 0, 1, 8)); drain();
    abort = 1'b1;
    issue(2'b01, 8'd1, 8'd2, 8'd251, 1, mk(3, 0, 1, 1));
    abort = 1'b0;
    drain();

    // Random traffic with back-pressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      rm = $urandom_range(1, 255);
      ra = $urandom % rm;
      rb = $urandom % rm;
      ro = 2'($urandom_range(0, 3));
      issue(ro, W'(ra), W'(rb), W'(rm), 1, model(ro, ra, rb, rm));
    end
    drain();
    rnd_rdy = 1'b0;
    out_ready = 1'b1;

    // Wide instance: 2*3 mod p first, then random residues.
    for (int t = 0; t < 4; t++) begin
      if (t == 0) begin
        a_b = 256'd2; b_b = 256'd3;
      end else begin
        for (int k = 0; k < 8; k++) begin
          a_b[k*32 +: 32] = $urandom;
          b_b[k*32 +: 32] = $urandom;
        end
        a_b = a_b % PK1;
        b_b = b_b % PK1;
      end
      prod = ({256'd0, a_b} * {256'd0, b_b}) % {256'd0, PK1};
      n = 0;
      while (!in_ready_b && n < 100) begin @(negedge clk); n++; end
      if (!in_ready_b) fail_now("big_wait_in_ready");
      in_valid_b = 1'b1;
      @(negedge clk);
      in_valid_b = 1'b0;
      n = 0;
      while (!out_valid_b && n < 300) begin @(negedge clk); n++; end
      chk("big_latency", n, WB / DPCB);
      chk("big_p", p_b, prod[WB-1:0]);
      chk("big_out_err", out_err_b, 0);
      @(negedge clk);
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
